// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Brief    : TMDS receive decoder for one HDMI/DVI channel. Finds the 10-bit
//            word boundary by bitslipping until control tokens appear, then
//            decodes control periods to {C1,C0} and data periods to pixels.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout,
  output logic       locked,
  output logic       bitslip
);

  localparam logic [15:0] C_SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [15:0] C_LOSS_LAST   = 16'(LOSS_TIMEOUT - 1);
  localparam logic [7:0]  C_RUN_LAST    = 8'(CTRL_RUN - 1);
  localparam logic [7:0]  C_SLIP_WAIT   = 8'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timer, w_timer_nxt;   // search timer in SEARCH, loss timer in LOCKED
  logic [7:0]  r_run,   w_run_nxt;
  logic [7:0]  r_wait,  w_wait_nxt;
  logic        r_bitslip, w_bitslip_nxt;
  logic        r_locked,  w_locked_nxt;

  logic        r_de;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_dout;

  logic        w_is_ctrl;
  logic [1:0]  w_ctrl_val;
  logic [7:0]  w_d;
  logic [7:0]  w_byte;

  // Control-token classification of the incoming word
  always_comb begin
    w_is_ctrl  = 1'b1;
    w_ctrl_val = 2'b00;
    case (din)
      10'b1101010100: w_ctrl_val = 2'b00;
      10'b0010101011: w_ctrl_val = 2'b01;
      10'b0101010100: w_ctrl_val = 2'b10;
      10'b1010101011: w_ctrl_val = 2'b11;
      default:        w_is_ctrl  = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion, then the XOR/XNOR chain
  always_comb begin
    w_d       = din[9] ? ~din[7:0] : din[7:0];
    w_byte    = 8'h00;
    w_byte[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_byte[i] = din[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  // Alignment FSM next-state, counters and bitslip request
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_run_nxt     = r_run;
    w_wait_nxt    = r_wait;
    w_bitslip_nxt = 1'b0;
    w_locked_nxt  = r_locked;
    case (r_state)
      ST_SEARCH: begin
        if (r_bitslip) begin
          // pulse cycle: the deserialiser is shifting, settle count starts next
          w_wait_nxt = r_wait;
        end else if (r_wait != 8'd0) begin
          w_wait_nxt = r_wait - 8'd1;
        end else if (w_is_ctrl) begin
          // a token on the timeout cycle still wins over the bitslip
          w_state_nxt = ST_VERIFY;
          w_run_nxt   = 8'd1;
          w_timer_nxt = 16'd0;
        end else if (r_timer >= C_SEARCH_LAST) begin
          w_bitslip_nxt = 1'b1;
          w_wait_nxt    = C_SLIP_WAIT;
          w_timer_nxt   = 16'd0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      ST_VERIFY: begin
        if (w_is_ctrl) begin
          if (r_run != 8'hFF) begin
            w_run_nxt = r_run + 8'd1;
          end
          if (r_run >= C_RUN_LAST) begin
            w_state_nxt  = ST_LOCKED;
            w_locked_nxt = 1'b1;
            w_timer_nxt  = 16'd0;
          end
        end else begin
          // broken run: restart the search without shifting the boundary
          w_state_nxt = ST_SEARCH;
          w_run_nxt   = 8'd0;
          w_timer_nxt = 16'd0;
        end
      end
      ST_LOCKED: begin
        if (w_is_ctrl) begin
          w_timer_nxt = 16'd0;
        end else if (r_timer >= C_LOSS_LAST) begin
          w_state_nxt  = ST_SEARCH;
          w_locked_nxt = 1'b0;
          w_run_nxt    = 8'd0;
          w_timer_nxt  = 16'd0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_SEARCH;
        w_locked_nxt = 1'b0;
        w_run_nxt    = 8'd0;
        w_timer_nxt  = 16'd0;
        w_wait_nxt   = 8'd0;
      end
    endcase
  end

  // Alignment FSM state and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_SEARCH;
      r_timer   <= 16'd0;
      r_run     <= 8'd0;
      r_wait    <= 8'd0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_run     <= w_run_nxt;
      r_wait    <= w_wait_nxt;
      r_bitslip <= w_bitslip_nxt;
      r_locked  <= w_locked_nxt;
    end
  end

  // Decoded output registers; de is gated by the lock state before this edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
      r_dout <= 8'h00;
    end else begin
      r_de <= ~w_is_ctrl & r_locked;
      if (w_is_ctrl) begin
        r_ctrl <= w_ctrl_val;
      end else begin
        r_dout <= w_byte;
      end
    end
  end

  assign de      = r_de;
  assign ctrl    = r_ctrl;
  assign dout    = r_dout;
  assign locked  = r_locked;
  assign bitslip = r_bitslip;

endmodule
`default_nettype wire

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the TMDS encoder for one HDMI/DVI channel.
- Takes 10-bit parallel words from the channel deserialiser and aligns the word boundary with a bitslip search on control tokens.
- Decodes control periods into the 2-bit control value and data periods into 8-bit pixel data.
- Reports lock status to the downstream video timing recovery.

Parameters:
- CTRL_RUN, 8: consecutive control tokens required to declare lock (2..255).
- SEARCH_TIMEOUT, 2048: cycles in SEARCH without any control token before a bitslip is requested (16..65535).
- SLIP_WAIT, 8: settle cycles after a bitslip pulse before the search restarts (1..255).
- LOSS_TIMEOUT, 65535: cycles in LOCKED without any control token before lock is dropped (16..65535).

Ports:
- clk, input, 1: pixel clock; everything is sampled on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- din, input, 10: TMDS word from the deserialiser; bit 0 is first on the wire.
- de, output, 1: data enable; 1 = data period.
- ctrl, output, 2: decoded control value {C1,C0}; held during data periods.
- dout, output, 8: decoded pixel data; held during control periods.
- locked, output, 1: word alignment achieved.
- bitslip, output, 1: one-cycle request to the deserialiser to shift the word boundary by one bit.

Behaviour:
- Reset values (resetn=0, asynchronous): de=0, ctrl=0, dout=0, locked=0, bitslip=0, FSM=SEARCH, all counters 0.
- Token classification (combinational on din):
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
  - any other word is a data word.
- Data decode:
  - d = din[9] ? ~din[7:0] : din[7:0].
  - dout[0] = d[0].
  - For i = 1..7: dout[i] = din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output latency: exactly 1 clock. Outputs update on the edge that samples din.
  - Control token: de<=0, ctrl<=decoded value, dout holds.
  - Data word: de<=1, dout<=decoded byte, ctrl holds.
  - While locked=0, de is forced to 0; ctrl and dout still update.
- FSM, 3 states:
  - SEARCH:
    - Cycle timer increments each cycle.
    - Control token -> VERIFY, run=1, timer cleared.
    - Timer reaching SEARCH_TIMEOUT-1 -> bitslip=1 for exactly one cycle, then wait SLIP_WAIT cycles ignoring din, then restart SEARCH with timer=0.
    - Tokens arriving during the wait are ignored.
  - VERIFY:
    - Each control token increments run.
    - run reaching CTRL_RUN -> LOCKED; locked<=1 on that same edge.
    - A data word -> SEARCH, timer=0; no bitslip on this transition.
  - LOCKED:
    - Loss timer is cleared on every control token and increments otherwise.
    - Loss timer reaching LOSS_TIMEOUT-1 -> SEARCH; locked<=0 on that edge, de forced 0 from the next output.
- bitslip is asserted only in SEARCH and is never asserted in two consecutive cycles.
- Counters saturate and never wrap. The run counter is 8-bit; the timers are 16-bit.
- CTRL_RUN=1 is illegal; the minimum is 2.
- Same-edge token on the SEARCH timeout cycle: the token wins, FSM goes to VERIFY with no bitslip.
- Reset asserted mid-operation clears everything immediately, including a bitslip pulse in progress. Alignment restarts from SEARCH on release.

Test Plan:
- Reset, then a stream of 10'h354 (ctrl 00) -> locked=0 for 7 cycles, locked=1 after the 8th token, ctrl=00, de=0, bitslip never asserted.
- After lock, data words 10'h100 then 10'h200 -> 1 cycle later de=1, dout=8'h00, then dout=8'hFF; ctrl stays 00.
- Control tokens rotated right by 3 bits, with the bench model rotating one bit back per bitslip pulse, SEARCH_TIMEOUT=16 -> exactly 3 bitslip pulses, each at least SLIP_WAIT+16 cycles apart, then locked=1 after CTRL_RUN aligned tokens.
- In VERIFY, 5 tokens of 10'h0AB, then 10'h100, then tokens -> FSM returns to SEARCH with no bitslip; locked rises only after 8 fresh consecutive tokens; ctrl=01.
- Locked, then only data words with LOSS_TIMEOUT=32 -> locked falls after 32 cycles and de is 0 from the next output; a single token before cycle 32 keeps lock.
- resetn pulsed low for 1 cycle while bitslip=1 and locked=1 -> all outputs 0 immediately, asynchronously; relock requires a full CTRL_RUN sequence.
